// File: rtl/prng_share_ctrl.sv
// Shares one Galois LFSR between NREQ round-robin requesters; each grant returns a
// WIDTH-bit word built from WIDTH LFSR steps, delivered with a single-cycle one-hot grant.
module prng_share_ctrl #(
  parameter int unsigned        NREQ   = 4,
  parameter int unsigned        WIDTH  = 8,
  parameter int unsigned        LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              CLK,
  input  logic              BTN_N,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic              rnd_valid,
  output logic [WIDTH-1:0]  rnd_data,
  input  logic              seed_we,
  input  logic [LFSR_W-1:0] seed_data,
  output logic              busy
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e            state_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, seed_val;
  logic [WIDTH-1:0]  acc_q, acc_d, data_q;
  logic [CNTW-1:0]   cnt_q;
  logic [IDXW-1:0]   rr_q, idx_q, pick_idx, cand;
  logic              pick_found;
  logic [NREQ-1:0]   gnt_q;
  logic              valid_q, busy_q;

  // Round-robin pick: first set request scanning upward from the slot after rr_q.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDXW'((32'(rr_q) + k) % NREQ);
      if (!pick_found && req[cand]) begin
        pick_idx   = cand;
        pick_found = 1'b1;
      end
    end
  end

  // One Galois step; the shifted-out bit enters acc at the LSB so the first bit ends at the MSB.
  always_comb begin
    lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    acc_d    = WIDTH'({acc_q, lfsr_q[0]});
    seed_val = (seed_data == '0) ? SEED : seed_data;
  end

  always_ff @(posedge CLK) begin
    if (!BTN_N) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      acc_q   <= '0;
      cnt_q   <= '0;
      rr_q    <= IDXW'(NREQ - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      if (seed_we) begin
        // Seed load aborts any in-flight word and leaves the arbiter pointer alone.
        lfsr_q  <= seed_val;
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (|req) begin
              idx_q   <= pick_idx;
              cnt_q   <= '0;
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
          SHIFT: begin
            lfsr_q <= lfsr_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(WIDTH - 1)) begin
              state_q <= DONE;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            // A requester that dropped its line forfeits the word.
            if (req[idx_q]) begin
              gnt_q[idx_q] <= 1'b1;
              valid_q      <= 1'b1;
              data_q       <= acc_q;
              rr_q         <= idx_q;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = valid_q;
  assign rnd_data  = data_q;
  assign busy      = busy_q;

endmodule
